// File: rtl/hz_bcd_secuenciador.sv
// Frame-synchronous binary-to-BCD converter for the Hz LCD overlay (double-dabble, one bit per cycle).
// Optional macro HZ_SOLO_CAMBIO_EN: publish (and pulse valido) only when the value or saturation changes.
`timescale 1ns/1ps

module hz_bcd_secuenciador #(
    parameter int unsigned n_bits_freq   = 14,
    parameter int unsigned freq_max      = 10000,
    parameter int unsigned n_digitos_bcd = 5
) (
    input  logic                         NCLK,
    input  logic                         RESET,
    input  logic [n_bits_freq-1:0]       freq_Hz,
    input  logic                         fin_cuadro,
    output logic [4*n_digitos_bcd-1:0]   digitos,
    output logic [2:0]                   n_digitos,
    output logic                         saturado,
    output logic                         valido,
    output logic                         ocupado
);

    localparam int unsigned W_BCD = 4 * n_digitos_bcd;
    localparam int unsigned W_CNT = $clog2(n_bits_freq);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        CONVIERTE = 2'd1,
        PUBLICA   = 2'd2
    } estado_t;

    estado_t                r_estado;
    logic [n_bits_freq-1:0] r_bin;
    logic [W_BCD-1:0]       r_bcd;
    logic [W_CNT-1:0]       r_cnt;
    logic                   r_sat_pend;

    logic                   w_sat;
    logic [n_bits_freq-1:0] w_clamp;
    logic [W_BCD-1:0]       w_bcd_adj;
    logic [2:0]             w_n_dig;

    assign w_sat   = (32'(freq_Hz) > freq_max);
    assign w_clamp = w_sat ? n_bits_freq'(freq_max) : freq_Hz;

    // Add-3 correction on every nibble that would overflow after the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < int'(n_digitos_bcd); k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5)
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // Significant-digit count: position of the highest nonzero nibble, minimum 1
    always_comb begin
        w_n_dig = 3'd1;
        for (int k = 0; k < int'(n_digitos_bcd); k++) begin
            if (r_bcd[4*k +: 4] != 4'd0)
                w_n_dig = 3'(k + 1);
        end
    end

`ifdef HZ_SOLO_CAMBIO_EN
    logic w_igual;
    assign w_igual = (r_bcd == digitos) && (r_sat_pend == saturado);
`endif

    always_ff @(posedge NCLK or posedge RESET) begin
        if (RESET) begin
            r_estado   <= REPOSO;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_sat_pend <= 1'b0;
            digitos    <= '0;
            n_digitos  <= 3'd1;
            saturado   <= 1'b0;
            valido     <= 1'b0;
            ocupado    <= 1'b0;
        end else begin
            valido <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    ocupado <= fin_cuadro;
                    if (fin_cuadro) begin
                        r_bin      <= w_clamp;
                        r_bcd      <= '0;
                        r_cnt      <= W_CNT'(n_bits_freq - 1);
                        r_sat_pend <= w_sat;
                        r_estado   <= CONVIERTE;
                    end
                end
                CONVIERTE: begin
                    r_bcd <= {w_bcd_adj[W_BCD-2:0], r_bin[n_bits_freq-1]};
                    r_bin <= {r_bin[n_bits_freq-2:0], 1'b0};
                    if (r_cnt == '0)
                        r_estado <= PUBLICA;
                    else
                        r_cnt <= r_cnt - W_CNT'(1);
                end
                PUBLICA: begin
`ifdef HZ_SOLO_CAMBIO_EN
                    if (!w_igual) begin
                        digitos   <= r_bcd;
                        n_digitos <= w_n_dig;
                        saturado  <= r_sat_pend;
                        valido    <= 1'b1;
                    end
`else
                    digitos   <= r_bcd;
                    n_digitos <= w_n_dig;
                    saturado  <= r_sat_pend;
                    valido    <= 1'b1;
`endif
                    r_estado <= REPOSO;
                end
                default: begin
                    r_estado <= REPOSO;
                    ocupado  <= 1'b0;
                end
            endcase
        end
    end

endmodule
